tilexy_cl_drain: RTL and testbench

//  Downstream drain stage of the tile cache-line FIFO. Pops one 528-bit line (8 x 66-bit beats) with its
//  47-bit tile-qualified address and 12-bit size word, holds it in a 2-entry ping-pong line buffer, and

---
 rtl/tilexy_cl_drain_pkg.sv | 42 ++++
 rtl/tilexy_cl_drain_if.sv | 41 ++++
 rtl/tilexy_cl_drain_mask_next.sv | 32 +++
 rtl/tilexy_cl_drain.sv | 163 ++++++++++++++++
 tb/tb_tilexy_cl_drain.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tilexy_cl_drain_pkg.sv
// Shared types and constants for the tile cache-line drain stage.
// Covers line/beat geometry, the size-word field offsets and the drain FSM states.
package tilexy_cl_drain_pkg;

  localparam int BEAT_W     = 66;
  localparam int LINE_BEATS = 8;
  localparam int LINE_W     = BEAT_W * LINE_BEATS;
  localparam int BEAT_IDX_W = 3;
  localparam int ADDR_W     = 47;
  localparam int SIZE_W     = 12;
  localparam int WR_ADDR_W  = ADDR_W + BEAT_IDX_W;

  // Size word layout: [11]=shared, [10]=exclusive, [9:8]=reserved, [7:0]=beat mask
  localparam int SZ_SHARED  = 11;
  localparam int SZ_EXCL    = 10;
  localparam int SZ_MASK    = 0;

  typedef logic [LINE_BEATS-1:0] beat_mask_t;
  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  // Line as presented at the FIFO head
  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
  } cl_line_t;

  // Line as held in the ping-pong buffer; reserved size bits are not kept
  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        attr;
    beat_mask_t        mask;
  } cl_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    RETIRE
  } drain_state_e;

endpackage

// File: rtl/tilexy_cl_drain_if.sv
// Bus bundles around the drain stage: FIFO head (pop side) and bank write port.
// master is the driving side of each bundle; the drain is slave on the FIFO and master on the bank.
interface tilexy_cl_drain_fifo_if;
  import tilexy_cl_drain_pkg::*;

  logic              reqmort_vld;
  logic [LINE_W-1:0] reqmort_data;
  logic [ADDR_W-1:0] reqmortaddr;
  logic [SIZE_W-1:0] reqmort_size;
  logic              outen;

  modport master (
    output reqmort_vld, reqmort_data, reqmortaddr, reqmort_size,
    input  outen
  );

  modport slave (
    input  reqmort_vld, reqmort_data, reqmortaddr, reqmort_size,
    output outen
  );
endinterface

interface tilexy_cl_drain_bank_if;
  import tilexy_cl_drain_pkg::*;

  logic                 bank_wr_en;
  logic                 bank_wr_rdy;
  logic [WR_ADDR_W-1:0] bank_wr_addr;
  logic [BEAT_W-1:0]    bank_wr_data;
  logic [1:0]           bank_wr_attr;

  modport master (
    output bank_wr_en, bank_wr_addr, bank_wr_data, bank_wr_attr,
    input  bank_wr_rdy
  );

  modport slave (
    input  bank_wr_en, bank_wr_addr, bank_wr_data, bank_wr_attr,
    output bank_wr_rdy
  );
endinterface

// File: rtl/tilexy_cl_drain_mask_next.sv
// Beat selector: lowest set mask bit (lowest=1) or lowest set bit strictly above cur (lowest=0).
// none flags that no qualifying bit exists.
module tilexy_cl_drain_mask_next
  import tilexy_cl_drain_pkg::*;
(
  input  beat_mask_t mask,
  input  beat_idx_t  cur,
  input  logic       lowest,
  output beat_idx_t  nxt,
  output logic       none
);

  beat_mask_t cand;

  genvar gi;
  generate
    for (gi = 0; gi < LINE_BEATS; gi++) begin : g_cand
      assign cand[gi] = mask[gi] & (lowest | (beat_idx_t'(gi) > cur));
    end
  endgenerate

  // Scan downward so the lowest candidate wins
  always_comb begin
    nxt = '0;
    for (int i = LINE_BEATS - 1; i >= 0; i--) begin
      if (cand[i]) nxt = beat_idx_t'(i);
    end
  end

  assign none = ~|cand;

endmodule

// File: rtl/tilexy_cl_drain.sv
// Drain stage: pops cache lines into a 2-entry ping-pong buffer and streams the
// masked beats to the bank write port, pulsing line_done as each line retires.
module tilexy_cl_drain
  import tilexy_cl_drain_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  tilexy_cl_drain_fifo_if.slave  fifo,
  tilexy_cl_drain_bank_if.master bank,
  output logic                   line_done,
  output logic                   line_flush,
  output logic                   drain_busy
);

  cl_line_t  head;
  cl_entry_t entry_mem [2];
  cl_entry_t cur_entry;
  logic      rsvd_unused;

  logic [1:0] valid_reg, valid_next;
  logic       wr_ptr_reg, rd_ptr_reg;
  logic       pop, retire, accept;

  drain_state_e         state_reg, state_next;
  beat_idx_t            beat_reg, beat_next;
  beat_mask_t           mask_reg, mask_next;
  logic                 flush_reg, flush_next;
  logic [WR_ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [BEAT_W-1:0]    wr_data_reg, wr_data_next;
  logic [1:0]           attr_reg, attr_next;

  logic [BEAT_W-1:0] cur_beats [LINE_BEATS];
  beat_mask_t        sel_mask;
  logic              sel_lowest;
  beat_idx_t         sel_idx;
  logic              sel_none;

  assign head = '{data: fifo.reqmort_data, addr: fifo.reqmortaddr, size: fifo.reqmort_size};
  assign rsvd_unused = ^head.size[SZ_EXCL-1 -: 2];

  assign pop        = fifo.reqmort_vld & ~valid_reg[wr_ptr_reg];
  assign fifo.outen = pop;
  assign retire     = (state_reg == RETIRE);
  assign accept     = (state_reg == BEAT) & bank.bank_wr_rdy;
  assign cur_entry  = entry_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (pop) begin
      entry_mem[wr_ptr_reg] <= '{data: head.data,
                                 addr: head.addr,
                                 attr: {head.size[SZ_SHARED], head.size[SZ_EXCL]},
                                 mask: head.size[SZ_MASK +: LINE_BEATS]};
    end
  end

  generate
    for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : g_beat
      assign cur_beats[gi] = cur_entry.data[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  // Pop and retire never target the same index, so the two updates commute
  always_comb begin
    valid_next = valid_reg;
    if (retire) valid_next[rd_ptr_reg] = 1'b0;
    if (pop)    valid_next[wr_ptr_reg] = 1'b1;
  end

  // First beat comes from the fresh entry mask; later beats search above the current one
  assign sel_lowest = (state_reg == IDLE);
  assign sel_mask   = sel_lowest ? cur_entry.mask : mask_reg;

  tilexy_cl_drain_mask_next u_mask_sel (
    .mask   (sel_mask),
    .cur    (beat_reg),
    .lowest (sel_lowest),
    .nxt    (sel_idx),
    .none   (sel_none)
  );

  always_comb begin
    state_next   = state_reg;
    beat_next    = beat_reg;
    mask_next    = mask_reg;
    flush_next   = flush_reg;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    attr_next    = attr_reg;
    case (state_reg)
      IDLE: begin
        if (valid_reg[rd_ptr_reg]) begin
          if (sel_none) begin
            state_next = RETIRE;
            flush_next = 1'b1;
          end else begin
            state_next   = BEAT;
            flush_next   = 1'b0;
            beat_next    = sel_idx;
            mask_next    = cur_entry.mask;
            wr_addr_next = {cur_entry.addr, sel_idx};
            wr_data_next = cur_beats[sel_idx];
            attr_next    = cur_entry.attr;
          end
        end
      end
      BEAT: begin
        // Bus registers only move on accept, so a stalled beat stays put
        if (accept) begin
          mask_next[beat_reg] = 1'b0;
          if (sel_none) begin
            state_next = RETIRE;
          end else begin
            beat_next    = sel_idx;
            wr_addr_next = {cur_entry.addr, sel_idx};
            wr_data_next = cur_beats[sel_idx];
          end
        end
      end
      RETIRE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg   <= '0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      state_reg   <= IDLE;
      beat_reg    <= '0;
      mask_reg    <= '0;
      flush_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      attr_reg    <= '0;
    end else begin
      valid_reg   <= valid_next;
      if (pop)    wr_ptr_reg <= ~wr_ptr_reg;
      if (retire) rd_ptr_reg <= ~rd_ptr_reg;
      state_reg   <= state_next;
      beat_reg    <= beat_next;
      mask_reg    <= mask_next;
      flush_reg   <= flush_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      attr_reg    <= attr_next;
    end
  end

  assign bank.bank_wr_en   = (state_reg == BEAT);
  assign bank.bank_wr_addr = wr_addr_reg;
  assign bank.bank_wr_data = wr_data_reg;
  assign bank.bank_wr_attr = attr_reg;

  assign line_done  = retire;
  assign line_flush = retire & flush_reg;
  assign drain_busy = |valid_reg;

endmodule

// File: tb/tb_tilexy_cl_drain.sv
// Self-checking bench for tilexy_cl_drain: FIFO source queue, beat/line scoreboard,
// directed timing cases, mid-line reset and a long random run.
module tb_tilexy_cl_drain;
  import tilexy_cl_drain_pkg::*;

  localparam int CW = LINE_W;

  typedef struct packed {
    logic [WR_ADDR_W-1:0] addr;
    logic [BEAT_W-1:0]    data;
    logic [1:0]           attr;
  } exp_beat_t;

  typedef struct packed {
    logic flush;
    int   nbeats;
  } exp_line_t;

  logic clk = 1'b0;
  logic rst;
  logic line_done, line_flush, drain_busy;

  tilexy_cl_drain_fifo_if fifo_if ();
  tilexy_cl_drain_bank_if bank_if ();

  tilexy_cl_drain dut (
    .clk        (clk),
    .rst        (rst),
    .fifo       (fifo_if),
    .bank       (bank_if),
    .line_done  (line_done),
    .line_flush (line_flush),
    .drain_busy (drain_busy)
  );

  always #5 clk = ~clk;

  cl_line_t  src_q  [$];
  exp_beat_t beat_q [$];
  exp_line_t line_q [$];
  int        pop_cyc[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 never, 3 random
  int vld_gap  = 0;
  int n_pops, n_acc, n_done, n_flush, n_en, cur_beats;
  int first_en_cyc, first_done_cyc;

  task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic cl_line_t rand_line(input logic [SIZE_W-1:0] size);
    cl_line_t          l;
    logic [LINE_W-1:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
    d[512 +: 16] = 16'($urandom());
    l.data = d;
    l.addr = ADDR_W'({$urandom(), $urandom()});
    l.size = size;
    return l;
  endfunction

  task automatic push_expect(input cl_line_t l);
    exp_beat_t eb;
    exp_line_t el;
    int        nb;
    nb = 0;
    for (int b = 0; b < LINE_BEATS; b++) begin
      if (l.size[SZ_MASK + b]) begin
        eb.addr = {l.addr, 3'(b)};
        eb.data = l.data[b*BEAT_W +: BEAT_W];
        eb.attr = {l.size[SZ_SHARED], l.size[SZ_EXCL]};
        beat_q.push_back(eb);
        nb++;
      end
    end
    el.flush  = (nb == 0);
    el.nbeats = nb;
    line_q.push_back(el);
  endtask

  task automatic drive();
    logic go;
    go = (src_q.size() != 0) && (vld_gap == 0 || $urandom_range(3) != 0);
    fifo_if.reqmort_vld = go;
    if (src_q.size() != 0) begin
      fifo_if.reqmort_data = src_q[0].data;
      fifo_if.reqmortaddr  = src_q[0].addr;
      fifo_if.reqmort_size = src_q[0].size;
    end
    case (rdy_mode)
      0:       bank_if.bank_wr_rdy = 1'b1;
      1:       bank_if.bank_wr_rdy = ~bank_if.bank_wr_rdy;
      2:       bank_if.bank_wr_rdy = 1'b0;
      default: bank_if.bank_wr_rdy = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic monitor();
    exp_beat_t eb;
    exp_line_t el;
    if (bank_if.bank_wr_en) begin
      n_en++;
      if (first_en_cyc < 0) first_en_cyc = cyc;
      if (beat_q.size() == 0) begin
        check_val("beat_unexpected", CW'(bank_if.bank_wr_en), CW'(0));
      end else begin
        eb = beat_q[0];
        check_val("wr_addr", CW'(bank_if.bank_wr_addr), CW'(eb.addr));
        check_val("wr_data", CW'(bank_if.bank_wr_data), CW'(eb.data));
        check_val("wr_attr", CW'(bank_if.bank_wr_attr), CW'(eb.attr));
        if (bank_if.bank_wr_rdy) begin
          void'(beat_q.pop_front());
          n_acc++;
          cur_beats++;
        end
      end
    end
    if (line_done) begin
      n_done++;
      if (line_flush) n_flush++;
      if (first_done_cyc < 0) first_done_cyc = cyc;
      if (line_q.size() == 0) begin
        check_val("done_unexpected", CW'(line_done), CW'(0));
      end else begin
        el = line_q.pop_front();
        check_val("line_flush", CW'(line_flush), CW'(el.flush));
        check_val("line_beats", CW'(cur_beats), CW'(el.nbeats));
      end
      cur_beats = 0;
    end else if (line_flush) begin
      check_val("flush_without_done", CW'(line_flush), CW'(0));
    end
    if (fifo_if.outen) begin
      check_val("outen_needs_vld", CW'(fifo_if.reqmort_vld), CW'(1));
      if (src_q.size() != 0) begin
        push_expect(src_q.pop_front());
        n_pops++;
        pop_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_drain(input int budget);
    int k;
    k = 0;
    while ((src_q.size() != 0 || line_q.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    check_val("drain_timeout", CW'(src_q.size() + line_q.size()), CW'(0));
  endtask

  task automatic clear_counts();
    n_pops = 0; n_acc = 0; n_done = 0; n_flush = 0; n_en = 0;
    first_en_cyc = -1; first_done_cyc = -1;
    pop_cyc.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_outen"}, CW'(fifo_if.outen), CW'(0));
    check_val({tag, "_wr_en"}, CW'(bank_if.bank_wr_en), CW'(0));
    check_val({tag, "_wr_addr"}, CW'(bank_if.bank_wr_addr), CW'(0));
    check_val({tag, "_wr_data"}, CW'(bank_if.bank_wr_data), CW'(0));
    check_val({tag, "_wr_attr"}, CW'(bank_if.bank_wr_attr), CW'(0));
    check_val({tag, "_done"}, CW'(line_done), CW'(0));
    check_val({tag, "_flush"}, CW'(line_flush), CW'(0));
    check_val({tag, "_busy"}, CW'(drain_busy), CW'(0));
  endtask

  initial begin
    cl_line_t   l;
    logic [7:0] m;
    int         k;

    rst = 1'b0;
    fifo_if.reqmort_vld  = 1'b0;
    fifo_if.reqmort_data = '0;
    fifo_if.reqmortaddr  = '0;
    fifo_if.reqmort_size = '0;
    bank_if.bank_wr_rdy  = 1'b0;
    cur_beats = 0;
    clear_counts();

    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Full line, always ready: first beat in cycle 2, line_done in cycle 10
    clear_counts();
    rdy_mode = 0; cyc = 0;
    l = rand_line(12'h0FF);
    l.addr = 47'h1_2345;
    src_q.push_back(l);
    run_drain(100);
    $display("t1 full line: first_en=%0d done=%0d beats=%0d", first_en_cyc, first_done_cyc, n_acc);
    check_val("t1_first_en_cyc", CW'(first_en_cyc), CW'(2));
    check_val("t1_done_cyc", CW'(first_done_cyc), CW'(10));
    check_val("t1_beats", CW'(n_acc), CW'(8));
    check_val("t1_busy_after", CW'(drain_busy), CW'(0));

    // Sparse mask with ready toggling: beats 0 and 7 only, stalled beats held
    clear_counts();
    rdy_mode = 1;
    src_q.push_back(rand_line(12'h481));
    run_drain(100);
    $display("t2 mask 0x81: beats=%0d done=%0d", n_acc, n_done);
    check_val("t2_beats", CW'(n_acc), CW'(2));
    check_val("t2_done", CW'(n_done), CW'(1));

    // Empty mask: flush-only retire, no beats
    clear_counts();
    rdy_mode = 0;
    src_q.push_back(rand_line(12'h800));
    run_drain(100);
    $display("t3 flush line: en=%0d pops=%0d done=%0d flush=%0d", n_en, n_pops, n_done, n_flush);
    check_val("t3_no_wr_en", CW'(n_en), CW'(0));
    check_val("t3_pops", CW'(n_pops), CW'(1));
    check_val("t3_done", CW'(n_done), CW'(1));
    check_val("t3_flush", CW'(n_flush), CW'(1));

    // Three lines with bank stalled: only two fit in the buffer
    clear_counts();
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) src_q.push_back(rand_line(12'h0FF & (12'($urandom()) | 12'h001)));
    repeat (20) cycle();
    $display("t4 stalled: pops=%0d done=%0d busy=%0b", n_pops, n_done, drain_busy);
    check_val("t4_pops_stalled", CW'(n_pops), CW'(2));
    check_val("t4_done_stalled", CW'(n_done), CW'(0));
    check_val("t4_busy_stalled", CW'(drain_busy), CW'(1));
    rdy_mode = 0;
    run_drain(200);
    check_val("t4_pops_total", CW'(n_pops), CW'(3));
    if (pop_cyc.size() >= 3) begin
      $display("t4 third pop cycle=%0d first done cycle=%0d", pop_cyc[2], first_done_cyc);
      check_val("t4_third_pop_after_retire", CW'(pop_cyc[2] > first_done_cyc), CW'(1));
    end

    // Reset asserted while beat 3 of a line is on the bus
    clear_counts();
    rdy_mode = 0;
    src_q.push_back(rand_line(12'h3FF));
    k = 0;
    while (n_acc < 3 && k < 50) begin
      cycle();
      k++;
    end
    check_val("t5_reach_beat3", CW'(n_acc), CW'(3));
    #2;
    rst = 1'b0;
    fifo_if.reqmort_vld = 1'b0;
    #1;
    check_outputs_zero("t5_async_rst");
    src_q.delete(); beat_q.delete(); line_q.delete();
    cur_beats = 0;
    repeat (3) begin
      @(negedge clk);
      check_val("t5_rst_done", CW'(line_done), CW'(0));
      check_val("t5_rst_wr_en", CW'(bank_if.bank_wr_en), CW'(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    clear_counts();
    rdy_mode = 3;
    src_q.push_back(rand_line(12'hC5A));
    run_drain(100);
    $display("t5 after reset: pops=%0d done=%0d", n_pops, n_done);
    check_val("t5_resume_pops", CW'(n_pops), CW'(1));
    check_val("t5_resume_done", CW'(n_done), CW'(1));

    // Random masks, ready and valid gaps over many lines
    clear_counts();
    rdy_mode = 3;
    vld_gap  = 1;
    for (int i = 0; i < 1000; i++) begin
      k = $urandom_range(9);
      if (k == 0)      m = 8'h00;
      else if (k == 1) m = 8'hFF;
      else             m = 8'($urandom());
      src_q.push_back(rand_line({4'($urandom()), m}));
    end
    run_drain(40000);
    $display("t6 random: pops=%0d done=%0d beats=%0d flush=%0d", n_pops, n_done, n_acc, n_flush);
    check_val("t6_done", CW'(n_done), CW'(1000));
    check_val("t6_beats_left", CW'(beat_q.size()), CW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
